// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
// Optional checksum output: define ROM_STREAM_CHECKSUM_EN.
package rom_stream_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W = 9;
    localparam int ROM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/rom_stream_reader_out_reg.sv
// Single-entry valid/ready output register carrying data and last.
// free tells the sequencer a new beat can be loaded this cycle.
module rom_stream_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              free,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer reading a combinational ROM into a valid/ready byte stream.
// Optional checksum port: define ROM_STREAM_CHECKSUM_EN.
module rom_stream_reader #(
    parameter int ADDR_W = rom_stream_pkg::ADDR_W,
    parameter int DATA_W = rom_stream_pkg::DATA_W,
    parameter int LEN_W  = rom_stream_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_ce,
    output logic              rom_read_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    import rom_stream_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  len_clamp;
    logic              issue;
    logic              free;
    logic              last_in;

    assign len_clamp = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
    assign last_in   = (rem_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = len_clamp;
                    if (len_clamp == '0) done_d = 1'b1;
                    else state_d = READ;
                end
            end
            READ: begin
                if (free) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (last_in) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last beat is the only one left in the output register.
                if (out_valid && out_ready && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign rom_address = addr_q;
    assign rom_ce      = issue;
    assign rom_read_en = issue;

    rom_stream_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (issue),
        .in_data  (rom_data),
        .in_last  (last_in),
        .free     (free),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

`ifdef ROM_STREAM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state_q == IDLE && start) begin
            checksum <= '0;
        end else if (out_valid && out_ready) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed self-checking bench for rom_stream_reader.
// Checksum checks compile in when ROM_STREAM_CHECKSUM_EN is defined.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] length = '0;
    logic       busy, done;
    logic [7:0] rom_address;
    logic       rom_ce, rom_read_en;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid, out_last;
    logic       out_ready = 1'b1;
`ifdef ROM_STREAM_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rom_data = mem[rom_address];

    rom_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_address(rom_address),
        .rom_ce     (rom_ce),
        .rom_read_en(rom_read_en),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
`ifdef ROM_STREAM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_ce"}, rom_ce, 0);
        chk({tag, "_rd"}, rom_read_en, 0);
        chk({tag, "_addr"}, rom_address, 0);
    endtask

    // Runs one burst and scores every issue and beat against mem[i]=i.
    task automatic run_burst(input logic [7:0] base, input logic [8:0] len,
                             input int n, input bit stall, input bit poke);
        int idx = 0;
        int iss = 0;
        bit seen = 0;
        bit pstall = 0;
        logic [7:0] pdata = '0;
        logic [7:0] e;
        logic [7:0] sum = '0;
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        length = len;
        out_ready = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 2000 && !seen; c++) begin
            if (poke && c == 1) begin
                start = 1'b1;
                base_addr = 8'h80;
                length = 9'd5;
            end else begin
                start = 1'b0;
            end
            out_ready = stall ? (c % 3 == 0) : 1'b1;
            #1;
            if (done) begin
                chk("beats", idx, n);
                chk("issues", iss, n);
                chk("busy_at_done", busy, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
                chk("checksum", checksum, sum);
`endif
                seen = 1;
            end else begin
                if (pstall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, pdata);
                end
                if (rom_ce) begin
                    e = base + iss[7:0];
                    chk("rom_addr", rom_address, e);
                    iss++;
                end
                if (out_valid && !out_ready) chk("stall_ce", rom_ce, 0);
                if (out_valid && out_ready) begin
                    e = base + idx[7:0];
                    chk("data", out_data, e);
                    chk("last", out_last, idx == n - 1);
                    sum = sum + out_data;
                    idx++;
                end
                pstall = out_valid && !out_ready;
                pdata = out_data;
            end
            if (!seen) @(negedge clk);
        end
        start = 1'b0;
        if (!seen) chk("timeout", 0, 1);
        @(negedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("after_valid", out_valid, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Burst of 4 with exact cycle timing.
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h10;
        length = 9'd4;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("b4_t1_busy", busy, 1);
        chk("b4_t1_ce", rom_ce, 1);
        chk("b4_t1_rd", rom_read_en, 1);
        chk("b4_t1_addr", rom_address, 8'h10);
        chk("b4_t1_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("b4_valid", out_valid, 1);
            chk("b4_data", out_data, 8'h10 + i);
            chk("b4_last", out_last, i == 3);
            chk("b4_done", done, 0);
        end
        chk("b4_drain_ce", rom_ce, 0);
        @(negedge clk);
        #1;
        chk("b4_done_pulse", done, 1);
        chk("b4_done_busy", busy, 0);
        chk("b4_done_valid", out_valid, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
        chk("b4_checksum", checksum, 8'h46);
`endif
        @(negedge clk);
        #1;
        chk("b4_done_once", done, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
        chk("b4_checksum_hold", checksum, 8'h46);
`endif

        run_burst(8'hFE, 9'd4, 4, 1'b0, 1'b0);
        run_burst(8'h20, 9'd3, 3, 1'b1, 1'b0);
        run_burst(8'h00, 9'd300, 256, 1'b0, 1'b0);
        run_burst(8'h40, 9'd3, 3, 1'b0, 1'b1);

        // Zero-length command.
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h55;
        length = 9'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_valid", out_valid, 0);
        @(negedge clk);
        #1;
        chk("len0_done_once", done, 0);
        chk("len0_busy2", busy, 0);
        chk("len0_valid2", out_valid, 0);

        // Reset after two beats.
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h20;
        length = 9'd8;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_beat0", out_data, 8'h20);
        @(negedge clk);
        #1;
        chk("rst_beat1", out_data, 8'h21);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_idle_outputs("midrst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_burst(8'h30, 9'd5, 5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
